uart_tx_arbiter: RTL and testbench

- Shares one 8N1 UART transmitter among NUM_REQ byte-stream requesters.
- Arbitration is round-robin at packet granularity. A requester keeps the grant until it sends a byte flagged Last, or until its inter-byte timeout expires.
- Sits between the command/telemetry sources and the UART transmitter. Drives the transmitter's data-valid and byte inputs, and observes its active and done outputs.

---
 rtl/uart_tx_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one 8N1 UART transmitter among
// NUM_REQ byte-stream requesters, with an inter-byte hold timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic [IDX_W-1:0]     o_Grant_Idx,
  output logic                 o_Busy,
  output logic                 o_Timeout,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done
);

  localparam int unsigned CNT_W = 24;
  localparam logic [CNT_W-1:0] TO_LIMIT =
    (TIMEOUT_CLKS == 0) ? '0 : CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               tx_dv_q, tx_dv_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_prev_q, done_prev_d;

  logic               done_rise;
  logic [NUM_REQ-1:0] dv_rot;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [7:0]         win_byte;
  logic               win_last;
  logic [7:0]         own_byte;
  logic               own_dv;
  logic               own_last;
  logic [IDX_W-1:0]   ptr_next;
  int unsigned        pos;

  assign done_rise = i_Tx_Done & ~done_prev_q;
  assign ptr_next  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

  // Round-robin pick: rotate requests so the pointer lands at bit 0, take the first.
  always_comb begin
    dv_rot    = NUM_REQ'({i_Req_DV, i_Req_DV} >> ptr_q);
    win_found = 1'b0;
    win_oh    = '0;
    pos       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && dv_rot[i]) begin
        win_found = 1'b1;
        pos       = 32'(ptr_q) + i;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        win_oh    = NUM_REQ'(1) << pos;
      end
    end
  end

  // Byte/last muxes for the round-robin winner and for the current owner.
  always_comb begin
    win_byte = '0;
    win_idx  = '0;
    own_byte = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_oh[k]) begin
        win_byte = i_Req_Byte[k*8 +: 8];
        win_idx  = IDX_W'(k);
      end
      if (grant_q[k]) own_byte = i_Req_Byte[k*8 +: 8];
    end
    win_last = |(i_Req_Last & win_oh);
    own_dv   = |(i_Req_DV & grant_q);
    own_last = |(i_Req_Last & grant_q);
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    tx_byte_d   = tx_byte_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    done_prev_d = i_Tx_Done;
    tx_dv_d     = 1'b0;
    ack_d       = '0;
    timeout_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (win_found && !i_Tx_Active) begin
          state_d   = S_WAIT;
          grant_d   = win_oh;
          idx_d     = win_idx;
          busy_d    = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = win_byte;
          ack_d     = win_oh;
          last_d    = win_last;
        end
      end
      S_WAIT: begin
        if (done_rise) begin
          if (last_q) begin
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = ptr_next;
          end else begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
      end
      S_HOLD: begin
        // A launch takes precedence over a timeout expiring in the same cycle.
        if (own_dv && !i_Tx_Active) begin
          state_d   = S_WAIT;
          tx_dv_d   = 1'b1;
          tx_byte_d = own_byte;
          ack_d     = grant_q;
          last_d    = own_last;
        end else if (TIMEOUT_CLKS != 0 && cnt_q == TO_LIMIT) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          ptr_d     = ptr_next;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      ack_q       <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      ack_q       <= ack_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      done_prev_q <= done_prev_d;
    end
  end

  assign o_Req_Ack   = ack_q;
  assign o_Grant     = grant_q;
  assign o_Grant_Idx = idx_q;
  assign o_Busy      = busy_q;
  assign o_Timeout   = timeout_q;
  assign o_Tx_DV     = tx_dv_q;
  assign o_Tx_Byte   = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, checked
// every cycle against a behavioural arbitration model and a launch log.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TO = 50;
  localparam int QD = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_dv;
  logic [8*NR-1:0] req_byte;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   ack;
  logic [NR-1:0]   grant;
  logic [IW-1:0]   grant_idx;
  logic            busy;
  logic            tmo;
  logic            tx_dv;
  logic [7:0]      tx_byte;
  logic            tx_active;
  logic            tx_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock(clk), .i_Rst_L(rst_n),
    .i_Req_DV(req_dv), .i_Req_Byte(req_byte), .i_Req_Last(req_last),
    .o_Req_Ack(ack), .o_Grant(grant), .o_Grant_Idx(grant_idx),
    .o_Busy(busy), .o_Timeout(tmo), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Requester byte queues: {last, byte}
  logic [8:0] rmem [NR][QD];
  int         rhead [NR];
  int         rtail [NR];
  bit         present [NR];
  bit         rnd;

  // Transmitter emulation
  int cfg_len, cfg_dlen, cfg_lag;
  bit tx_on;
  int tx_ph, tx_len, tx_dlen, tx_lag;
  bit done_drv_prev;
  int rise_at;
  logic act_prev;

  // Reference model
  int m_owner, m_ptr, m_hold;
  bit m_inflight, m_last, m_prev_done;
  logic          e_dv, e_busy, e_to;
  logic [7:0]    e_byte;
  logic [NR-1:0] e_ack, e_grant;
  logic [IW-1:0] e_idx;

  int log_idx[$], log_byte[$], exp_idx[$], exp_byte[$];
  int to_cnt, to_delay;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_req(input int k, input logic [7:0] b, input bit last);
    rmem[k][rtail[k] % QD] = {last, b};
    rtail[k]++;
  endtask

  task automatic exp_push(input int i, input int b);
    exp_idx.push_back(i);
    exp_byte.push_back(b);
  endtask

  task automatic model_launch(input int k);
    e_dv         = 1'b1;
    e_ack        = '0;
    e_ack[k]     = 1'b1;
    e_grant      = '0;
    e_grant[k]   = 1'b1;
    e_idx        = IW'(k);
    e_byte       = req_byte[k*8 +: 8];
    e_busy       = 1'b1;
    m_owner      = k;
    m_inflight   = 1'b1;
    m_last       = req_last[k];
  endtask

  task automatic model_release();
    m_ptr      = (m_owner + 1) % NR;
    m_owner    = -1;
    m_inflight = 1'b0;
    e_grant    = '0;
    e_busy     = 1'b0;
  endtask

  // Predicts outputs after the next clock edge from the inputs now being driven.
  task automatic model_step();
    bit rise;
    bit found;
    int k;
    rise        = tx_done && !m_prev_done;
    m_prev_done = tx_done;
    e_dv  = 1'b0;
    e_ack = '0;
    e_to  = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      if (!tx_active) begin
        for (int i = 0; i < NR; i++) begin
          k = (m_ptr + i) % NR;
          if (!found && req_dv[k]) begin
            found = 1'b1;
            model_launch(k);
          end
        end
      end
    end else if (m_inflight) begin
      if (rise) begin
        if (m_last) model_release();
        else begin
          m_inflight = 1'b0;
          m_hold     = 0;
        end
      end
    end else begin
      if (req_dv[m_owner] && !tx_active) model_launch(m_owner);
      else begin
        m_hold++;
        if (TO != 0 && m_hold == TO) begin
          model_release();
          e_to = 1'b1;
        end
      end
    end
  endtask

  task automatic update_stim();
    int n;
    for (int k = 0; k < NR; k++) begin
      if (e_ack[k]) begin
        rhead[k]++;
        present[k] = 1'b0;
      end
      if (rnd) begin
        if (rhead[k] == rtail[k] && $urandom_range(0, 15) == 0) begin
          n = int'($urandom_range(1, 4));
          for (int j = 0; j < n; j++) push_req(k, 8'($urandom), j == n - 1);
        end
        if (present[k] && $urandom_range(0, 29) == 0) present[k] = 1'b0;
        else if (!present[k] && rhead[k] != rtail[k] && $urandom_range(0, 2) == 0) present[k] = 1'b1;
      end else if (rhead[k] != rtail[k]) begin
        present[k] = 1'b1;
      end
    end

    if (e_dv) begin
      tx_on = 1'b1;
      tx_ph = 0;
      if (rnd) begin
        tx_len  = int'($urandom_range(2, 6));
        tx_dlen = int'($urandom_range(1, 3));
        tx_lag  = int'($urandom_range(0, 2));
      end else begin
        tx_len  = cfg_len;
        tx_dlen = cfg_dlen;
        tx_lag  = cfg_lag;
      end
    end else if (tx_on) begin
      tx_ph++;
    end
    if (tx_on) begin
      tx_active = (tx_ph < tx_len + tx_lag);
      tx_done   = (tx_ph >= tx_len) && (tx_ph < tx_len + tx_dlen);
      if (tx_ph >= tx_len + ((tx_lag > tx_dlen) ? tx_lag : tx_dlen)) tx_on = 1'b0;
    end else begin
      tx_active = 1'b0;
      tx_done   = 1'b0;
    end
    if (tx_done && !done_drv_prev) rise_at = cyc;
    done_drv_prev = tx_done;

    for (int k = 0; k < NR; k++) begin
      req_dv[k] = present[k];
      if (present[k]) begin
        req_byte[k*8 +: 8] = rmem[k][rhead[k] % QD][7:0];
        req_last[k]        = rmem[k][rhead[k] % QD][8];
      end else begin
        req_byte[k*8 +: 8] = 8'($urandom);
        req_last[k]        = 1'($urandom);
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("tx_dv", tx_dv, e_dv);
    check_eq("tx_byte", tx_byte, e_byte);
    check_eq("req_ack", ack, e_ack);
    check_eq("grant", grant, e_grant);
    check_eq("grant_idx", grant_idx, e_idx);
    check_eq("busy", busy, e_busy);
    check_eq("timeout", tmo, e_to);
    if (tx_dv) begin
      log_idx.push_back(int'(grant_idx));
      log_byte.push_back(int'(tx_byte));
      check_eq("launch_while_active", act_prev, 1'b0);
    end
    if (tmo) begin
      to_cnt++;
      to_delay = cyc - rise_at;
    end
  endtask

  task automatic step();
    update_stim();
    act_prev = tx_active;
    model_step();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  function automatic bit quiet();
    bit q;
    q = (m_owner < 0) && !tx_on;
    for (int k = 0; k < NR; k++) if (rhead[k] != rtail[k]) q = 1'b0;
    return q;
  endfunction

  task automatic run_until_log(input int n, input int budget);
    int c;
    c = 0;
    while (log_idx.size() < n && c < budget) begin
      step();
      c++;
    end
    if (log_idx.size() < n) check_eq("wait_launch_count", log_idx.size(), n);
  endtask

  task automatic run_until_quiet(input int budget);
    int c;
    c = 0;
    while (!quiet() && c < budget) begin
      step();
      c++;
    end
    if (!quiet()) begin
      n_checks++;
      n_errors++;
      $display("FAIL quiet_budget: still busy after %0d cycles, required idle", budget);
    end
    repeat (3) step();
    check_eq("idle_busy", busy, 1'b0);
  endtask

  task automatic compare_log(input string tag);
    int n;
    check_eq({tag, "_count"}, log_idx.size(), exp_idx.size());
    n = (log_idx.size() < exp_idx.size()) ? log_idx.size() : exp_idx.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_idx"}, log_idx[i], exp_idx[i]);
      check_eq({tag, "_byte"}, log_byte[i], exp_byte[i]);
    end
    exp_idx.delete();
    exp_byte.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_tx_dv", tx_dv, 1'b0);
    check_eq("rst_tx_byte", tx_byte, 8'h00);
    check_eq("rst_ack", ack, '0);
    check_eq("rst_grant", grant, '0);
    check_eq("rst_grant_idx", grant_idx, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_timeout", tmo, 1'b0);
    for (int k = 0; k < NR; k++) begin
      rhead[k]   = 0;
      rtail[k]   = 0;
      present[k] = 1'b0;
    end
    req_dv = '0; req_byte = '0; req_last = '0;
    tx_active = 1'b0; tx_done = 1'b0;
    tx_on = 1'b0; tx_ph = 0; done_drv_prev = 1'b0; rise_at = 0;
    m_owner = -1; m_ptr = 0; m_hold = 0;
    m_inflight = 1'b0; m_last = 1'b0; m_prev_done = 1'b0;
    e_dv = 1'b0; e_busy = 1'b0; e_to = 1'b0; e_byte = '0;
    e_ack = '0; e_grant = '0; e_idx = '0;
    log_idx.delete(); log_byte.delete();
    to_cnt = 0; to_delay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    rnd = 1'b0;
    cfg_len = 3; cfg_dlen = 1; cfg_lag = 0;
    req_dv = '0; req_byte = '0; req_last = '0;
    tx_active = 1'b0; tx_done = 1'b0;
    #2;

    // Single byte, then pointer moved past requester 1
    do_reset();
    push_req(1, 8'hA5, 1'b1);
    run_until_quiet(100);
    push_req(0, 8'h10, 1'b1);
    push_req(2, 8'h20, 1'b1);
    run_until_quiet(200);
    exp_push(1, 8'hA5); exp_push(2, 8'h20); exp_push(0, 8'h10);
    compare_log("single");

    // Fairness between two continuous requesters
    do_reset();
    push_req(0, 8'h01, 1'b1); push_req(0, 8'h02, 1'b1);
    push_req(2, 8'h03, 1'b1); push_req(2, 8'h04, 1'b1);
    run_until_quiet(300);
    exp_push(0, 8'h01); exp_push(2, 8'h03); exp_push(0, 8'h02); exp_push(2, 8'h04);
    compare_log("fair");

    // Packet lock
    do_reset();
    push_req(1, 8'h11, 1'b0); push_req(1, 8'h22, 1'b0); push_req(1, 8'h33, 1'b1);
    run_until_log(1, 20);
    push_req(0, 8'h44, 1'b1);
    run_until_quiet(300);
    exp_push(1, 8'h11); exp_push(1, 8'h22); exp_push(1, 8'h33); exp_push(0, 8'h44);
    compare_log("lock");

    // Hold timeout with a pending requester
    do_reset();
    push_req(3, 8'h7E, 1'b0);
    run_until_log(1, 20);
    push_req(0, 8'h55, 1'b1);
    run_until_quiet(300);
    exp_push(3, 8'h7E); exp_push(0, 8'h55);
    compare_log("timeout");
    check_eq("timeout_pulses", to_cnt, 1);
    check_eq("timeout_delay", to_delay, TO + 1);

    // Stretched done with active lingering after it
    do_reset();
    cfg_dlen = 2; cfg_lag = 2;
    push_req(1, 8'h61, 1'b0); push_req(1, 8'h62, 1'b1);
    run_until_quiet(200);
    exp_push(1, 8'h61); exp_push(1, 8'h62);
    compare_log("stretch");
    cfg_dlen = 1; cfg_lag = 0;

    // Reset in the middle of a packet
    do_reset();
    push_req(2, 8'h81, 1'b0); push_req(2, 8'h82, 1'b0);
    push_req(2, 8'h83, 1'b0); push_req(2, 8'h84, 1'b1);
    run_until_log(2, 50);
    do_reset();
    push_req(2, 8'h83, 1'b0); push_req(2, 8'h84, 1'b1);
    push_req(0, 8'h90, 1'b1);
    run_until_quiet(300);
    exp_push(0, 8'h90); exp_push(2, 8'h83); exp_push(2, 8'h84);
    compare_log("midreset");

    // Random traffic, then drain
    do_reset();
    rnd = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;
    run_until_quiet(3000);
    check_eq("random_launches_seen", (log_idx.size() > 20) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
